// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter.
// Holds the FSM state encoding, the port IDs used for arbitration and
// bookkeeping, and the fixed data-path width of the memory.
package mem_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  // Port IDs; also the bit index of each port in the one-hot winner vector.
  localparam logic ARB_PORT_I = 1'b0;
  localparam logic ARB_PORT_D = 1'b1;

  localparam int DATA_WIDTH = 32;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker.
// Ports:
//   req_i  [1:0]  request vector, bit 0 = instruction port, bit 1 = data port
//   last_i        ID of the port granted most recently
//   win_o  [1:0]  one-hot winner, all zero when nothing is requested
module rr_pick2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] win_o
);

  // A lone request always wins; on a tie the port not granted last wins.
  always_comb begin
    win_o = 2'b00;
    case (req_i)
      2'b01:   win_o = 2'b01;
      2'b10:   win_o = 2'b10;
      2'b11:   win_o = (last_i == ARB_PORT_D) ? 2'b01 : 2'b10;
      default: win_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port, fixed-latency memory between the
// instruction-fetch port (i_*) and the load/store port (d_*).
// One transaction is outstanding at a time; the two ports are served
// round-robin and read data comes back through registered outputs.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   i_req/i_addr               instruction read request
//   i_gnt/i_rvalid/i_rdata     instruction grant pulse and read response
//   d_req/d_we/d_addr/d_wmask/d_wdata   data request
//   d_gnt/d_rvalid/d_rdata     data grant pulse (write completion) and read response
//   mem_en/mem_we/mem_addr/mem_wmask/mem_wdata/mem_rdata   memory macro side
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [31:0]           i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [3:0]            d_wmask,
  input  logic [31:0]           d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [31:0]           d_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [3:0]            mem_wmask,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  localparam int CNT_W = $clog2(READ_LATENCY + 1);

  arb_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  last_gnt_q, last_gnt_d;
  logic                  port_q, port_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [3:0]            wmask_q, wmask_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  i_gnt_q, i_gnt_d, d_gnt_q, d_gnt_d, mem_en_q, mem_en_d;
  logic                  i_rvalid_q, i_rvalid_d, d_rvalid_q, d_rvalid_d;
  logic [31:0]           i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic [1:0]            win_s;
  logic                  unused_addr_bits_s;

  // Byte-offset bits of the word addresses are deliberately ignored.
  assign unused_addr_bits_s = ^{i_addr[1:0], d_addr[1:0]};

  rr_pick2 u_pick (
    .req_i  ({d_req, i_req}),
    .last_i (last_gnt_q),
    .win_o  (win_s)
  );

  // Next-state and next-output logic; pulses default low, everything else holds.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_gnt_d = last_gnt_q;
    port_d     = port_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wmask_d    = wmask_q;
    wdata_d    = wdata_q;
    i_gnt_d    = 1'b0;
    d_gnt_d    = 1'b0;
    mem_en_d   = 1'b0;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    case (state_q)
      ARB_IDLE: begin
        if (win_s != 2'b00) begin
          // Latch the winner's request so later changes on its inputs do not matter.
          state_d    = ARB_ISSUE;
          port_d     = win_s[ARB_PORT_D];
          last_gnt_d = win_s[ARB_PORT_D];
          mem_en_d   = 1'b1;
          i_gnt_d    = win_s[ARB_PORT_I];
          d_gnt_d    = win_s[ARB_PORT_D];
          if (win_s[ARB_PORT_D]) begin
            addr_d  = {d_addr[ADDR_WIDTH-1:2], 2'b00};
            we_d    = d_we;
            wmask_d = d_we ? d_wmask : 4'b0000;
            wdata_d = d_we ? d_wdata : 32'h0000_0000;
          end else begin
            addr_d  = {i_addr[ADDR_WIDTH-1:2], 2'b00};
            we_d    = 1'b0;
            wmask_d = 4'b0000;
            wdata_d = 32'h0000_0000;
          end
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_ISSUE: begin
        if (we_q) begin
          state_d = ARB_IDLE;
        end else begin
          // WAIT lasts READ_LATENCY cycles: count from L-1 down to 0.
          state_d = ARB_WAIT;
          cnt_d   = CNT_W'(READ_LATENCY - 1);
        end
      end
      ARB_WAIT: begin
        if (cnt_q == CNT_W'(0)) begin
          // mem_rdata is valid in this last WAIT cycle.
          state_d = ARB_RESP;
          if (port_q == ARB_PORT_D) begin
            d_rdata_d  = mem_rdata;
            d_rvalid_d = 1'b1;
          end else begin
            i_rdata_d  = mem_rdata;
            i_rvalid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and registered outputs; async reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ARB_IDLE;
      cnt_q      <= CNT_W'(0);
      last_gnt_q <= ARB_PORT_D;
      port_q     <= ARB_PORT_I;
      addr_q     <= {ADDR_WIDTH{1'b0}};
      we_q       <= 1'b0;
      wmask_q    <= 4'b0000;
      wdata_q    <= 32'h0000_0000;
      i_gnt_q    <= 1'b0;
      d_gnt_q    <= 1'b0;
      mem_en_q   <= 1'b0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= 32'h0000_0000;
      d_rdata_q  <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_gnt_q <= last_gnt_d;
      port_q     <= port_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wmask_q    <= wmask_d;
      wdata_q    <= wdata_d;
      i_gnt_q    <= i_gnt_d;
      d_gnt_q    <= d_gnt_d;
      mem_en_q   <= mem_en_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  assign i_gnt     = i_gnt_q;
  assign i_rvalid  = i_rvalid_q;
  assign i_rdata   = i_rdata_q;
  assign d_gnt     = d_gnt_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wmask = wmask_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench: instance A uses READ_LATENCY=1, instance B
// uses READ_LATENCY=3. Each has a small word memory whose read data is only
// non-zero in exactly the cycle the latency promises.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  // Instance A (L=1)
  logic a_i_req, a_i_gnt, a_i_rvalid, a_d_req, a_d_we, a_d_gnt, a_d_rvalid;
  logic a_mem_en, a_mem_we;
  logic [31:0] a_i_addr, a_d_addr, a_mem_addr, a_i_rdata, a_d_rdata, a_d_wdata, a_mem_wdata, a_mem_rdata;
  logic [3:0] a_d_wmask, a_mem_wmask;
  // Instance B (L=3)
  logic b_i_req, b_i_gnt, b_i_rvalid, b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
  logic b_mem_en, b_mem_we;
  logic [31:0] b_i_addr, b_d_addr, b_mem_addr, b_i_rdata, b_d_rdata, b_d_wdata, b_mem_wdata, b_mem_rdata;
  logic [3:0] b_d_wmask, b_mem_wmask;

  logic a_any_out, b_any_out;
  assign a_any_out = |{a_i_gnt, a_i_rvalid, a_i_rdata, a_d_gnt, a_d_rvalid, a_d_rdata,
                       a_mem_en, a_mem_we, a_mem_addr, a_mem_wmask, a_mem_wdata};
  assign b_any_out = |{b_i_gnt, b_i_rvalid, b_i_rdata, b_d_gnt, b_d_rvalid, b_d_rdata,
                       b_mem_en, b_mem_we, b_mem_addr, b_mem_wmask, b_mem_wdata};

  mem_arbiter #(.ADDR_WIDTH(32), .READ_LATENCY(1)) u_dut_a (
    .clk(clk), .reset(reset),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_gnt(a_i_gnt), .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wmask(a_d_wmask), .d_wdata(a_d_wdata),
    .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wmask(a_mem_wmask),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata));

  mem_arbiter #(.ADDR_WIDTH(32), .READ_LATENCY(3)) u_dut_b (
    .clk(clk), .reset(reset),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wmask(b_d_wmask), .d_wdata(b_d_wdata),
    .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wmask(b_mem_wmask),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata));

  // Memory models: preload while reset is low; read data appears L cycles after mem_en, 0 otherwise.
  function automatic logic [31:0] preload(int k);
    if (k == 65) return 32'h00A0_0093;      // byte address 0x104
    else if (k == 16) return 32'hDEAD_BEEF; // byte address 0x040
    else return 32'h1000_0000 | 32'(k);
  endfunction

  logic [31:0] mem_a [0:255];
  logic [31:0] mem_b [0:255];
  logic [31:0] pipe_a;
  logic [31:0] pipe_b [0:2];
  assign a_mem_rdata = pipe_a;
  assign b_mem_rdata = pipe_b[2];

  always @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 256; k++) mem_a[k] <= preload(k);
      pipe_a <= 32'h0;
    end else begin
      pipe_a <= (a_mem_en && !a_mem_we) ? mem_a[a_mem_addr[9:2]] : 32'h0;
      if (a_mem_en && a_mem_we)
        for (int b = 0; b < 4; b++)
          if (a_mem_wmask[b]) mem_a[a_mem_addr[9:2]][8*b +: 8] <= a_mem_wdata[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 256; k++) mem_b[k] <= preload(k);
      for (int s = 0; s < 3; s++) pipe_b[s] <= 32'h0;
    end else begin
      pipe_b[0] <= (b_mem_en && !b_mem_we) ? mem_b[b_mem_addr[9:2]] : 32'h0;
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (a_any_out !== 1'b0) begin n_fail++; $display("FAIL reset_outs_a: got %b expected 0", a_any_out); end
    n_checks++; if (b_any_out !== 1'b0) begin n_fail++; $display("FAIL reset_outs_b: got %b expected 0", b_any_out); end
    @(negedge clk);
    reset = 1'b1;
    tick();
    n_checks++; if (a_any_out !== 1'b0) begin n_fail++; $display("FAIL idle_outs_a: got %b expected 0", a_any_out); end
  endtask

  task automatic test_i_read();
    tick();
    a_i_req = 1'b1; a_i_addr = 32'h0000_0104;                      // cycle T
    tick();                                                          // T+1
    n_checks++; if (a_i_gnt !== 1'b1) begin n_fail++; $display("FAIL iread_gnt: got %b expected 1", a_i_gnt); end
    n_checks++; if (a_d_gnt !== 1'b0) begin n_fail++; $display("FAIL iread_dgnt: got %b expected 0", a_d_gnt); end
    n_checks++; if (a_mem_en !== 1'b1) begin n_fail++; $display("FAIL iread_en: got %b expected 1", a_mem_en); end
    n_checks++; if (a_mem_addr !== 32'h0000_0104) begin n_fail++; $display("FAIL iread_addr: got %h expected 00000104", a_mem_addr); end
    n_checks++; if ({a_mem_we, a_mem_wmask} !== 5'b0) begin n_fail++; $display("FAIL iread_we: got %b expected 0", {a_mem_we, a_mem_wmask}); end
    a_i_req = 1'b0; a_i_addr = 32'hFFFF_FFFF;
    tick();                                                          // T+2
    n_checks++; if ({a_i_rvalid, a_mem_en} !== 2'b00) begin n_fail++; $display("FAIL iread_wait: got %b expected 00", {a_i_rvalid, a_mem_en}); end
    tick();                                                          // T+3
    n_checks++; if (a_i_rvalid !== 1'b1) begin n_fail++; $display("FAIL iread_rvalid: got %b expected 1", a_i_rvalid); end
    n_checks++; if (a_i_rdata !== 32'h00A0_0093) begin n_fail++; $display("FAIL iread_rdata: got %h expected 00a00093", a_i_rdata); end
    tick();                                                          // T+4
    n_checks++; if (a_i_rvalid !== 1'b0) begin n_fail++; $display("FAIL iread_rvalid_pulse: got %b expected 0", a_i_rvalid); end
    n_checks++; if (a_i_rdata !== 32'h00A0_0093) begin n_fail++; $display("FAIL iread_rdata_hold: got %h expected 00a00093", a_i_rdata); end
  endtask

  task automatic test_write();
    tick();
    a_d_req = 1'b1; a_d_we = 1'b1; a_d_addr = 32'h0000_0203;       // cycle T
    a_d_wmask = 4'b1000; a_d_wdata = 32'hAB00_0000;
    tick();                                                          // T+1
    n_checks++; if ({a_d_gnt, a_i_gnt, a_mem_en, a_mem_we} !== 4'b1011) begin n_fail++; $display("FAIL wr_strobes: got %b expected 1011", {a_d_gnt, a_i_gnt, a_mem_en, a_mem_we}); end
    n_checks++; if (a_mem_addr !== 32'h0000_0200) begin n_fail++; $display("FAIL wr_addr: got %h expected 00000200", a_mem_addr); end
    n_checks++; if (a_mem_wmask !== 4'b1000) begin n_fail++; $display("FAIL wr_wmask: got %b expected 1000", a_mem_wmask); end
    n_checks++; if (a_mem_wdata !== 32'hAB00_0000) begin n_fail++; $display("FAIL wr_wdata: got %h expected ab000000", a_mem_wdata); end
    a_d_req = 1'b0; a_d_we = 1'b0; a_d_wmask = 4'b0000; a_d_wdata = 32'h0;
    tick();                                                          // T+2, should be IDLE
    n_checks++; if ({a_d_gnt, a_mem_en, a_d_rvalid} !== 3'b000) begin n_fail++; $display("FAIL wr_done: got %b expected 000", {a_d_gnt, a_mem_en, a_d_rvalid}); end
    a_i_req = 1'b1; a_i_addr = 32'h0000_0104;                      // IDLE samples this
    tick();                                                          // T+3
    n_checks++; if (a_i_gnt !== 1'b1) begin n_fail++; $display("FAIL wr_idle_next: got %b expected 1", a_i_gnt); end
    a_i_req = 1'b0;
    tick(); tick();                                                  // T+5 RESP
    n_checks++; if ({a_i_rvalid, a_d_rvalid} !== 2'b10) begin n_fail++; $display("FAIL wr_no_drvalid: got %b expected 10", {a_i_rvalid, a_d_rvalid}); end
  endtask

  task automatic test_back_to_back();
    tick();
    a_i_req = 1'b1; a_i_addr = 32'h0000_0104;                      // T
    tick();                                                          // T+1 ISSUE
    a_i_req = 1'b0;
    tick();                                                          // T+2 WAIT: data read arrives
    a_d_req = 1'b1; a_d_we = 1'b0; a_d_addr = 32'h0000_0200;
    tick();                                                          // T+3 RESP
    n_checks++; if ({a_i_rvalid, a_d_gnt} !== 2'b10) begin n_fail++; $display("FAIL b2b_resp: got %b expected 10", {a_i_rvalid, a_d_gnt}); end
    tick();                                                          // T+4 IDLE
    n_checks++; if (a_d_gnt !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b expected 0", a_d_gnt); end
    tick();                                                          // T+5 ISSUE
    n_checks++; if (a_d_gnt !== 1'b1) begin n_fail++; $display("FAIL b2b_dgnt: got %b expected 1", a_d_gnt); end
    n_checks++; if ({a_mem_we, a_mem_wmask} !== 5'b0) begin n_fail++; $display("FAIL b2b_rd_mask: got %b expected 0", {a_mem_we, a_mem_wmask}); end
    a_d_req = 1'b0;
    tick(); tick();                                                  // T+7 RESP
    n_checks++; if ({a_d_rvalid, a_i_rvalid} !== 2'b10) begin n_fail++; $display("FAIL b2b_drvalid: got %b expected 10", {a_d_rvalid, a_i_rvalid}); end
    n_checks++; if (a_d_rdata !== 32'hAB00_0080) begin n_fail++; $display("FAIL b2b_rdata: got %h expected ab000080", a_d_rdata); end
  endtask

  task automatic test_d_read_l3();
    tick();
    b_i_req = 1'b1; b_i_addr = 32'h0000_0104;                      // establish i_rdata
    tick();
    b_i_req = 1'b0;
    repeat (4) tick();                                               // T+5 RESP
    n_checks++; if ({b_i_rvalid, b_i_rdata} !== {1'b1, 32'h00A0_0093}) begin n_fail++; $display("FAIL l3_iread: got %b/%h expected 1/00a00093", b_i_rvalid, b_i_rdata); end
    tick();
    b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h0000_0040;       // T
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) begin
        n_checks++; if (b_d_gnt !== 1'b1) begin n_fail++; $display("FAIL l3_dgnt: got %b expected 1", b_d_gnt); end
        b_d_req = 1'b0;
      end
      n_checks++; if (b_d_rvalid !== (k == 5)) begin n_fail++; $display("FAIL l3_drvalid_T+%0d: got %b expected %b", k, b_d_rvalid, (k == 5)); end
      n_checks++; if (b_i_rvalid !== 1'b0) begin n_fail++; $display("FAIL l3_irvalid_T+%0d: got %b expected 0", k, b_i_rvalid); end
      n_checks++; if (b_i_rdata !== 32'h00A0_0093) begin n_fail++; $display("FAIL l3_irdata_T+%0d: got %h expected 00a00093", k, b_i_rdata); end
    end
    n_checks++; if (b_d_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL l3_drdata: got %h expected deadbeef", b_d_rdata); end
  endtask

  task automatic test_reset_mid();
    tick();
    b_i_req = 1'b1; b_i_addr = 32'h0000_0104;                      // T
    tick();                                                          // T+1 ISSUE
    b_i_req = 1'b0;
    tick();                                                          // T+2 WAIT
    #2;
    reset = 1'b0;
    #1;                                                              // still before the next edge
    n_checks++; if (b_any_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_outs_b: got %b expected 0", b_any_out); end
    n_checks++; if (a_any_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_outs_a: got %b expected 0", a_any_out); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_checks++; if ({b_i_rvalid, b_d_rvalid} !== 2'b00) begin n_fail++; $display("FAIL rst_mid_rvalid_%0d: got %b expected 00", k, {b_i_rvalid, b_d_rvalid}); end
    end
    b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h0000_0040;       // T
    tick();
    n_checks++; if ({b_d_gnt, b_i_gnt} !== 2'b10) begin n_fail++; $display("FAIL rst_mid_regnt: got %b expected 10", {b_d_gnt, b_i_gnt}); end
    b_d_req = 1'b0;
    repeat (4) tick();                                               // T+5
    n_checks++; if ({b_d_rvalid, b_d_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin n_fail++; $display("FAIL rst_mid_reread: got %b/%h expected 1/deadbeef", b_d_rvalid, b_d_rdata); end
  endtask

  task automatic test_round_robin();
    logic gseq [0:3];
    int ng = 0;
    logic d_rearm = 1'b0;
    a_d_we = 1'b1; a_d_addr = 32'h0000_0300; a_d_wmask = 4'b1111; a_d_wdata = 32'h1234_5678;
    a_i_addr = 32'h0000_0104;
    a_i_req = 1'b1; a_d_req = 1'b1;                                  // first tie since reset
    for (int c = 0; c < 40 && ng < 4; c++) begin
      tick();
      if (d_rearm) begin a_d_req = 1'b1; d_rearm = 1'b0; end
      n_checks++; if ((a_i_gnt & a_d_gnt) !== 1'b0) begin n_fail++; $display("FAIL rr_both_gnt: got %b expected 0", a_i_gnt & a_d_gnt); end
      if (a_i_gnt) begin gseq[ng] = 1'b0; ng++; a_i_req = 1'b0; end
      if (a_i_rvalid) a_i_req = 1'b1;
      if (a_d_gnt) begin gseq[ng] = 1'b1; ng++; a_d_req = 1'b0; d_rearm = 1'b1; end
    end
    a_i_req = 1'b0; a_d_req = 1'b0; a_d_we = 1'b0;
    n_checks++; if (ng !== 4) begin n_fail++; $display("FAIL rr_grant_count: got %0d expected 4", ng); end
    for (int k = 0; k < 4 && k < ng; k++) begin
      n_checks++; if (gseq[k] !== k[0]) begin n_fail++; $display("FAIL rr_order_%0d: got %s expected %s", k, gseq[k] ? "D" : "I", k[0] ? "D" : "I"); end
    end
    repeat (8) tick();
  endtask

  initial begin
    a_i_req = 1'b0; a_i_addr = 32'h0; a_d_req = 1'b0; a_d_we = 1'b0;
    a_d_addr = 32'h0; a_d_wmask = 4'b0000; a_d_wdata = 32'h0;
    b_i_req = 1'b0; b_i_addr = 32'h0; b_d_req = 1'b0; b_d_we = 1'b0;
    b_d_addr = 32'h0; b_d_wmask = 4'b0000; b_d_wdata = 32'h0;
    test_reset();
    test_i_read();
    test_write();
    test_back_to_back();
    test_d_read_l3();
    test_reset_mid();
    test_round_robin();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one single-port, fixed-read-latency memory between the instruction-fetch port and the load/store port of the multi-cycle rv32i core, so the core can run from a unified RAM. It sits between the core's instruction/data memory interfaces and the memory macro. It serialises accesses with one transaction outstanding at a time, picks between the two ports round-robin, and returns read data through a registered response.

## Interface
- `ADDR_WIDTH`, 32, byte-address width on all ports.
- `READ_LATENCY`, 1, cycles from `mem_en` to valid `mem_rdata`; legal range is 1 to 7.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  instruction read request; held until `i_gnt`.
- `i_addr`  in  ADDR_WIDTH  instruction word address, with [1:0] ignored.
- `i_gnt`  out  1  one-cycle pulse; request accepted and issued to memory.
- `i_rvalid`  out  1  one-cycle pulse; `i_rdata` is valid.
- `i_rdata`  out  32  instruction word.
- `d_req`  in  1  data request; held until `d_gnt`.
- `d_we`  in  1  1 selects a write, 0 selects a read.
- `d_addr`  in  ADDR_WIDTH  data word address, with [1:0] ignored.
- `d_wmask`  in  4  byte write enables.
- `d_wdata`  in  32  write data, already lane-aligned.
- `d_gnt`  out  1  one-cycle pulse; for writes it also marks completion.
- `d_rvalid`  out  1  one-cycle pulse for reads only.
- `d_rdata`  out  32  raw word; sign extension and shifting stay in the core.
- `mem_en`  out  1  one-cycle memory strobe.
- `mem_we`  out  1  write strobe; qualified by `mem_en`.
- `mem_addr`  out  ADDR_WIDTH  word-aligned address, with [1:0] forced to 0.
- `mem_wmask`  out  4  byte enables; 0 on reads.
- `mem_wdata`  out  32  write data.
- `mem_rdata`  in  32  valid exactly READ_LATENCY cycles after the `mem_en` cycle.

## Operation
- FSM states:
  - IDLE: sample `i_req`/`d_req`.
  - ISSUE: drive memory for one cycle and pulse the grant.
  - WAIT: count down READ_LATENCY cycles.
  - RESP: pulse rvalid for one cycle.
- Transitions:
  - IDLE→ISSUE when any request is present.
  - ISSUE→IDLE for a write.
  - ISSUE→WAIT for a read.
  - WAIT→RESP after READ_LATENCY cycles.
  - RESP→IDLE.
- Arbitration happens only in IDLE.
  - With a single request, that port wins.
  - When both request, the port not granted last wins.
  - `last_gnt` resets to data, so the first tie goes to instruction.
  - `last_gnt` updates on every grant.
- On the IDLE→ISSUE edge, address, we, wmask and wdata are registered from the winner; the winner's ID is kept until RESP.
- Instruction accesses always drive `mem_we`=0 and `mem_wmask`=0.
- Read data: `mem_rdata` is captured on the last WAIT cycle and presented on the winner's rdata in RESP.
- The rdata registers hold their value until the next capture.
- A requester that drops req before its grant is allowed; no access is generated for it.
- A requester that changes address/data before its grant is allowed; the value sampled in IDLE is used.

## Timing
- Reset value of every output is 0; state resets to IDLE, the counter to 0, and `last_gnt` to data.
- Read: req seen in cycle T; ISSUE and gnt in T+1; WAIT in T+2 through T+1+L; rvalid in T+2+L; IDLE in T+3+L.
  - Throughput is one read per L+3 cycles.
- Write: req seen in T; ISSUE, gnt and memory write in T+1; IDLE in T+2.
  - Throughput is one write per 2 cycles.
- Requesters must drop req on the edge ending the gnt cycle. A req still high in IDLE is treated as a new request.
- Exactly one of `i_gnt`/`d_gnt` is high, and only in ISSUE. `mem_en` is high only in ISSUE.
- At most one rvalid is high, and only in RESP.
- Async reset mid-transaction returns to IDLE immediately.
  - The pending read is dropped with no rvalid.
  - Outputs go to 0 without waiting for a clock edge.
- A request arriving during ISSUE, WAIT or RESP waits for IDLE and is never lost while held.

## Structure
- Additions to `defines.v`:
  - State encodings `ARB_IDLE`, `ARB_ISSUE`, `ARB_WAIT`, `ARB_RESP`.
  - Port IDs `ARB_PORT_I`=0 and `ARB_PORT_D`=1.
- Counter width is $clog2(READ_LATENCY+1).
- One sub-module, `rr_pick2`: a combinational 2-way round-robin picker with inputs req[1:0] and last, and output a one-hot winner. Everything else is a single FSM in `mem_arbiter`.

## Test plan
- `i_req` only, `i_addr`=0x104, L=1, memory returns 0x00A00093:
  - `i_gnt` in T+1 with `mem_addr`=0x104.
  - `i_rvalid` in T+3 with `i_rdata`=0x00A00093.
- `d_req` write to 0x203, `d_wmask`=0b1000, `d_wdata`=0xAB000000:
  - `mem_addr`=0x200, `mem_we`=1, `mem_wmask`=0b1000 in T+1, together with `d_gnt`.
  - IDLE in T+2.
  - No `d_rvalid`.
- Both ports requesting continuously, with each requester re-raising req after its response:
  - Grants go I, D, I, D.
  - The first grant after reset goes to I.
- L=3 data read of 0x40 returning 0xDEADBEEF:
  - `d_rvalid` in exactly T+5.
  - `i_rvalid` stays 0.
  - `i_rdata` is unchanged.
- `reset` asserted low during WAIT:
  - All outputs read 0 before the next edge.
  - No rvalid after release.
  - The next request is granted normally.
